// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
// It launches one frame at a time, then tracks TX_BUSY until the frame completes or is abandoned.
module uart_tx_arbiter #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]            REQ_PAR_TYP,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          TX_BUSY,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          Data_Valid,
  output logic                          PAR_EN,
  output logic                          PAR_TYP,
  output logic [$clog2(NUM_REQ)-1:0]    GRANT_ID,
  output logic                          ACTIVE,
  output logic                          FRAME_DONE,
  output logic                          TIMEOUT_ERR
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       win_idx;
  logic [ID_W-1:0]       cand;
  logic                  win_found;
  logic                  grant_c;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  timeout_c;

  logic [NUM_REQ-1:0]    req_ready_d;
  logic [DATA_WIDTH-1:0] p_data_d;
  logic                  data_valid_d;
  logic                  par_en_d;
  logic                  par_typ_d;
  logic [ID_W-1:0]       grant_id_d;
  logic                  active_d;
  logic                  frame_done_d;
  logic                  timeout_err_d;

  // Per-requester byte lanes of the flat data bus
  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign req_bytes[g] = REQ_DATA[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotating search: first valid requester at or after the pointer, with wrap
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (32'(ptr_q) + k >= NUM_REQ) begin
        cand = ID_W'(32'(ptr_q) + k - NUM_REQ);
      end else begin
        cand = ID_W'(32'(ptr_q) + k);
      end
      if (!win_found && REQ_VALID[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant_c   = (state_q == IDLE) && !TX_BUSY && win_found;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign timeout_c = (cnt_inc == CNT_W'(BUSY_TIMEOUT));

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; busy is only looked at once the strobe has gone out
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_c) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_d = WAIT_DONE;
        end else if (timeout_c) begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath next values; frame fields hold until the next grant
  always_comb begin
    req_ready_d   = '0;
    data_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    timeout_err_d = 1'b0;
    p_data_d      = P_DATA;
    par_en_d      = PAR_EN;
    par_typ_d     = PAR_TYP;
    grant_id_d    = GRANT_ID;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    active_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (grant_c) begin
          req_ready_d[win_idx] = 1'b1;
          data_valid_d         = 1'b1;
          p_data_d             = req_bytes[win_idx];
          par_en_d             = REQ_PAR_EN[win_idx];
          par_typ_d            = REQ_PAR_TYP[win_idx];
          grant_id_d           = win_idx;
          ptr_d                = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        end
      end
      LAUNCH: begin
        cnt_d = '0;
      end
      WAIT_BUSY: begin
        if (!TX_BUSY) begin
          cnt_d         = cnt_inc;
          timeout_err_d = timeout_c;
        end
      end
      WAIT_DONE: begin
        frame_done_d = !TX_BUSY;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Registered outputs, pointer and timeout counter
  always_ff @(posedge CLK) begin
    if (!RST) begin
      REQ_READY   <= '0;
      P_DATA      <= '0;
      Data_Valid  <= 1'b0;
      PAR_EN      <= 1'b0;
      PAR_TYP     <= 1'b0;
      GRANT_ID    <= '0;
      ACTIVE      <= 1'b0;
      FRAME_DONE  <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      REQ_READY   <= req_ready_d;
      P_DATA      <= p_data_d;
      Data_Valid  <= data_valid_d;
      PAR_EN      <= par_en_d;
      PAR_TYP     <= par_typ_d;
      GRANT_ID    <= grant_id_d;
      ACTIVE      <= active_d;
      FRAME_DONE  <= frame_done_d;
      TIMEOUT_ERR <= timeout_err_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
